// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcode, FSM state and requester-id definitions shared by the ALU op scheduler.
// Imported by alu_rr_arb2 and alu_op_scheduler.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Latency counter is wide enough for the largest legal ALU_LAT (15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } sched_state_e;

  function automatic logic [1:0] id_to_grant(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-way grant logic; round-robin by default, fixed req0-first priority
// when ALU_SCHED_FIXED_PRIO_EN is defined.
module alu_rr_arb2
  import alu_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

`ifdef ALU_SCHED_FIXED_PRIO_EN
  logic unused_s;
  assign unused_s = ^{clk, rst_n, accept_i};

  // Fixed priority: requester 0 always wins.
  always_comb begin
    if (req_i[0]) begin
      grant_o = id_to_grant(REQ0);
    end else if (req_i[1]) begin
      grant_o = id_to_grant(REQ1);
    end else begin
      grant_o = 2'b00;
    end
  end
`else
  logic last_q;
  logic last_d;

  // Contention goes to the requester that was not granted last.
  always_comb begin
    if (req_i == 2'b11) begin
      grant_o = (last_q == REQ0) ? id_to_grant(REQ1) : id_to_grant(REQ0);
    end else if (req_i[0]) begin
      grant_o = id_to_grant(REQ0);
    end else if (req_i[1]) begin
      grant_o = id_to_grant(REQ1);
    end else begin
      grant_o = 2'b00;
    end
  end

  // Pointer moves only when the grant is actually taken.
  always_comb begin
    if (accept_i) begin
      last_d = grant_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Reset value REQ1 makes the first contention go to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: two-requester front end for the shared ALU; one op in flight at a time.
// Build option: ALU_SCHED_FIXED_PRIO_EN selects fixed req0-first arbitration.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

  sched_state_e     state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             alu_start_q, alu_start_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_s;
  logic             idle_s;
  logic             accept_s;

  alu_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (accept_s),
    .grant_o  (grant_s)
  );

  // Ready is offered only in IDLE and never while reset is asserted.
  assign idle_s     = (state_q == IDLE) && rst_n;
  assign req0_ready = idle_s && grant_s[0];
  assign req1_ready = idle_s && grant_s[1];
  assign accept_s   = req0_ready || req1_ready;

  // Next-state, operand latch and latency counter.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    alu_start_d  = 1'b0;
    resp_valid_d = resp_valid_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = ISSUE;
          id_d        = grant_s[1];
          op_d        = grant_s[1] ? req1_op : req0_op;
          a_d         = grant_s[1] ? req1_a  : req0_a;
          b_d         = grant_s[1] ? req1_b  : req0_b;
          alu_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          data_d       = alu_result;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      id_q         <= REQ0;
      cnt_q        <= {CNT_W{1'b0}};
      data_q       <= {WIDTH{1'b0}};
      alu_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      alu_start_q  <= alu_start_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_start  = alu_start_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: transaction-level arbitration/ALU model, queue-based checking.
module tb_alu_op_scheduler;
  localparam int W    = 8;
  localparam int LAT  = 1;
  localparam int LAT4 = 4;

  typedef struct packed { logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; } req_t;
  typedef struct packed { logic id; logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b1;
  logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, alu_start, resp_valid, resp_id, busy;
  logic [1:0] alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result, resp_data;

  alu_op_scheduler #(.WIDTH(W), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  // Second instance with a longer ALU latency, exercised by one directed op.
  logic v4 = 1'b0, z_v = 1'b0, rr4 = 1'b1;
  logic [1:0] op4 = 2'b00, z_op = 2'b00;
  logic [W-1:0] a4 = '0, b4 = '0, z_a = '0, z_b = '0;
  logic rdy4, r1rdy4, s4_start, s4_rv, s4_id, s4_busy;
  logic [1:0] s4_op;
  logic [W-1:0] s4_a, s4_b, s4_res, s4_data;

  alu_op_scheduler #(.WIDTH(W), .ALU_LAT(LAT4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v4), .req0_op(op4), .req0_a(a4), .req0_b(b4), .req0_ready(rdy4),
    .req1_valid(z_v), .req1_op(z_op), .req1_a(z_a), .req1_b(z_b), .req1_ready(r1rdy4),
    .alu_start(s4_start), .alu_op(s4_op), .alu_a(s4_a), .alu_b(s4_b), .alu_result(s4_res),
    .resp_valid(s4_rv), .resp_ready(rr4), .resp_id(s4_id), .resp_data(s4_data), .busy(s4_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // Winner by the arbitration rule, given who was granted last.
  function automatic logic pick(input logic v0, input logic v1, input logic last);
`ifdef ALU_SCHED_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return ~last;
    return v0 ? 1'b0 : 1'b1;
`endif
  endfunction

  // ALU models: result valid only in the cycle exactly LAT cycles after alu_start, junk otherwise.
  int st_cyc = -100, st4_cyc = -100;
  logic [W-1:0] st_val = '0, st4_val = '0;
  always @(posedge clk) begin
    if (alu_start) begin st_cyc <= cyc; st_val <= alu_f(alu_op, alu_a, alu_b); end
    if (s4_start) begin st4_cyc <= cyc; st4_val <= alu_f(s4_op, s4_a, s4_b); end
  end
  assign alu_result = (cyc == st_cyc + LAT) ? st_val : (st_val ^ 8'hA5);
  assign s4_res     = (cyc == st4_cyc + LAT4) ? st4_val : (st4_val ^ 8'hA5);

  function automatic logic [31:0] outs();
    return {req0_ready, req1_ready, alu_start, alu_op, alu_a, alu_b, resp_valid, resp_id, resp_data, busy};
  endfunction
  function automatic logic [31:0] outs4();
    return {rdy4, r1rdy4, s4_start, s4_op, s4_a, s4_b, s4_rv, s4_id, s4_data, s4_busy};
  endfunction

  // Scoreboard state
  txn_t exp_q[$];
  req_t q0[$], q1[$];
  logic inflight = 1'b0;
  logic last_id = 1'b1;
  int hs_cyc = 0;
  int resp_cnt[2] = '{0, 0};
  logic m_w;
  logic [1:0] m_rdy;
  logic m_start, m_rv;
  txn_t m_t;

  // Monitor: grant prediction, issue/hold checks, and response pop-and-compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!inflight) begin
        m_w = pick(req0_valid, req1_valid, last_id);
        m_rdy = (req0_valid || req1_valid) ? (m_w ? 2'b10 : 2'b01) : 2'b00;
        chk("grant", {req1_ready, req0_ready}, m_rdy);
        if (m_rdy != 2'b00) begin
          m_t.id  = m_w;
          m_t.op  = m_w ? req1_op : req0_op;
          m_t.a   = m_w ? req1_a  : req0_a;
          m_t.b   = m_w ? req1_b  : req0_b;
          m_t.res = alu_f(m_t.op, m_t.a, m_t.b);
          exp_q.push_back(m_t);
          inflight = 1'b1;
          hs_cyc   = cyc;
          last_id  = m_w;
        end
      end else if (req0_ready || req1_ready) begin
        chk("ready_while_busy", {req1_ready, req0_ready}, 2'b00);
      end
      chk("busy", busy, inflight && (cyc > hs_cyc));
      m_start = inflight && (cyc == hs_cyc + 1);
      if (alu_start || m_start) chk("alu_start", alu_start, m_start);
      if (inflight && cyc > hs_cyc && exp_q.size() > 0)
        chk("alu_op_a_b", {alu_op, alu_a, alu_b}, {exp_q[0].op, exp_q[0].a, exp_q[0].b});
      m_rv = inflight && (cyc >= hs_cyc + 2 + LAT);
      if (resp_valid || m_rv) chk("resp_valid", resp_valid, m_rv);
      if (resp_valid && m_rv && exp_q.size() > 0) begin
        chk("resp_id", resp_id, exp_q[0].id);
        chk("resp_data", resp_data, exp_q[0].res);
        if (resp_ready) begin
          resp_cnt[exp_q[0].id]++;
          void'(exp_q.pop_front());
          inflight = 1'b0;
        end
      end
    end
  end

  // Driver
  int dly0 = 0, dly1 = 0;
  logic bp_arm = 1'b0;
  int bp_seen = 0;

  task automatic run(input int budget, input bit rnd);
    int n;
    logic acc0, acc1;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || inflight) && n < budget) begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (bp_arm && resp_valid) bp_seen++;
      @(posedge clk);
      #1;
      n++;
      if (acc0) begin req0_valid = 1'b0; void'(q0.pop_front()); end
      if (acc1) begin req1_valid = 1'b0; void'(q1.pop_front()); end
      if (!req0_valid && q0.size() > 0 && n >= dly0 && (!rnd || $urandom_range(2) != 0)) begin
        req0_valid = 1'b1; req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b;
      end
      if (!req1_valid && q1.size() > 0 && n >= dly1 && (!rnd || $urandom_range(2) != 0)) begin
        req1_valid = 1'b1; req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b;
      end
      if (bp_arm && bp_seen < 10) resp_ready = 1'b0;
      else begin
        bp_arm = 1'b0;
        resp_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
    chk("run_timeout", (n >= budget), 1'b0);
    resp_ready = 1'b1;
  endtask

  int c0, c1, t4;
  logic got;
  req_t r;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    chk("reset_outputs_lat4", outs4(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", outs(), 32'd0);

    // req0 ADD 5+3
    q0.push_back({2'b00, 8'h05, 8'h03});
    run(50, 1'b0);

    // both requesters streaming, four ops each
    c0 = resp_cnt[0]; c1 = resp_cnt[1];
    for (int i = 0; i < 4; i++) begin
      q0.push_back({2'(i), 8'(8'h20 + i), 8'h02});
      q1.push_back({2'(3 - i), 8'(8'h40 + i), 8'h07});
    end
    run(200, 1'b0);
    chk("req0_resp_count", resp_cnt[0] - c0, 32'd4);
    chk("req1_resp_count", resp_cnt[1] - c1, 32'd4);

    // response back-pressure with req1 waiting
    q0.push_back({2'b10, 8'hF0, 8'h3C});
    q1.push_back({2'b11, 8'h0F, 8'h30});
    dly1 = 3; bp_arm = 1'b1; bp_seen = 0;
    run(100, 1'b0);
    dly1 = 0;
    chk("backpressure_cycles", bp_seen, 32'd10);

    // reset pulse while the op waits for the ALU
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'h33; req0_b = 8'h11;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req0_ready;
    end
    chk("abort_grant", got, 1'b1);
    @(posedge clk); #1; req0_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'd0);
    exp_q.delete(); inflight = 1'b0; last_id = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", {resp_valid, busy, alu_start}, 3'b000);
    end
    q1.push_back({2'b00, 8'h7F, 8'h01});
    run(50, 1'b0);

    // all four opcodes from req1
    for (int i = 0; i < 4; i++) q1.push_back({2'(i), 8'($urandom), 8'($urandom)});
    run(100, 1'b0);

    // randomized traffic with random gaps and back-pressure
    for (int i = 0; i < 30; i++) begin
      r = {2'($urandom), 8'($urandom), 8'($urandom)};
      if ($urandom_range(1) == 0) q0.push_back(r); else q1.push_back(r);
    end
    run(2000, 1'b1);

    // ALU_LAT=4 instance: SUB 0x10 - 0x01
    @(posedge clk); #1;
    v4 = 1'b1; op4 = 2'b01; a4 = 8'h10; b4 = 8'h01;
    got = 1'b0; t4 = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rdy4) begin got = 1'b1; t4 = cyc; end
    end
    chk("lat4_grant", got, 1'b1);
    @(posedge clk); #1; v4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lat4_alu_start", s4_start, (cyc == t4 + 1));
      chk("lat4_resp_valid", s4_rv, (cyc == t4 + 6));
      if (cyc == t4 + 1) chk("lat4_alu_op", s4_op, 2'b01);
      if (cyc == t4 + 6) begin
        chk("lat4_resp_data", s4_data, 8'h0F);
        chk("lat4_resp_id", s4_id, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
